dmem_bank: RTL and testbench

DMEM_BANK -- requirements
Module: dmem_bank

---
 rtl/dmem_bank.sv | 158 +++++++++++++++
 tb/tb_dmem_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bank
//  Purpose  : Single-port word-addressed data memory with a request/response
//             handshake. After reset the whole array is swept to zero, one
//             word per cycle, and then requests are accepted every cycle.
//             Every accepted request is acknowledged by a one-cycle respValid
//             pulse on the following cycle. A request whose address is
//             >= DEPTH is flagged with addrErr. Such a write does not touch
//             memory, and such a read returns zero.
//  Macro    : DMEM_BYTE_EN - when defined, adds the byteEn port so that a
//             write updates only the selected byte lanes.
//  Ports    : clk        - clock, rising edge
//             reset      - synchronous active-high reset (restarts the clear)
//             reqValid   - request present
//             reqReady   - block accepts a request this cycle
//             memWrite   - 1 = write, 0 = read
//             address    - word address (ADDR_WIDTH bits)
//             writeData  - write data (DATA_WIDTH bits)
//             byteEn     - per-byte write enables (DMEM_BYTE_EN only)
//             respValid  - one-cycle acknowledge, one cycle after accept
//             readData   - registered read result, held between reads
//             addrErr    - out-of-range flag, qualified by respValid
//             busy       - memory clear in progress
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic                    memWrite,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   writeData,
`ifdef DMEM_BYTE_EN
    input  logic [DATA_WIDTH/8-1:0] byteEn,
`endif
    output logic                    respValid,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    addrErr,
    output logic                    busy
);

    // Index width into the storage array. DEPTH <= 2**ADDR_WIDTH, so this
    // never exceeds ADDR_WIDTH.
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The range compare is one bit wider than the address. This keeps the
    // compare exact when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] c_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [c_IDX_W-1:0]  c_LAST      = c_IDX_W'(DEPTH - 1);
`ifdef DMEM_BYTE_EN
    localparam int c_LANES = DATA_WIDTH / 8;
`endif

    localparam logic [0:0] c_S_CLEAR = 1'b0;
    localparam logic [0:0] c_S_READY = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [c_IDX_W-1:0]    r_clr_cnt;
    logic [c_IDX_W-1:0]    w_clr_cnt_next;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_resp_valid;
    logic                  r_addr_err;

    logic                  w_accept;
    logic                  w_in_range;
    logic [c_IDX_W-1:0]    w_idx;

    assign w_in_range = ({1'b0, address} < c_DEPTH_EXT);
    assign w_accept   = reqValid && (r_state == c_S_READY);
    assign w_idx      = address[c_IDX_W-1:0];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        case (r_state)
            c_S_CLEAR: begin
                if (r_clr_cnt == c_LAST) begin
                    w_state_next   = c_S_READY;
                    w_clr_cnt_next = '0;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                end
            end
            c_S_READY: begin
                w_state_next = c_S_READY;
            end
            default: begin
                w_state_next   = c_S_CLEAR;
                w_clr_cnt_next = '0;
            end
        endcase
    end

    assign busy     = (r_state == c_S_CLEAR);
    assign reqReady = (r_state == c_S_READY);

    // ------------------------------------------------------------- storage
    // The array has no reset. The clear sweep zeroes it instead. A reset
    // cycle writes nothing, so that a request presented alongside reset
    // leaves no trace.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == c_S_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_accept && memWrite && w_in_range) begin
`ifdef DMEM_BYTE_EN
                for (int b = 0; b < c_LANES; b++) begin
                    if (byteEn[b]) begin
                        r_mem[w_idx][b*8 +: 8] <= writeData[b*8 +: 8];
                    end
                end
`else
                r_mem[w_idx] <= writeData;
`endif
            end
        end
    end

    // ------------------------------------------------------------ response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data  <= '0;
            r_resp_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_accept;
            r_addr_err   <= w_accept && !w_in_range;
            // readData moves only on a read response. Writes leave it alone.
            if (w_accept && !memWrite) begin
                r_read_data <= w_in_range ? r_mem[w_idx] : '0;
            end
        end
    end

    assign respValid = r_resp_valid;
    assign readData  = r_read_data;
    assign addrErr   = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_bank
//  Purpose  : Self-checking bench for dmem_bank at default parameters.
//             A behavioural model tracks the remaining clear cycles, the
//             memory contents and the expected response. One compare process
//             checks every DUT output against this model on each cycle.
//             Directed literal checks pin the model itself.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bank;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic          memWrite = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] writeData = '0;
`ifdef DMEM_BYTE_EN
    logic [DW/8-1:0] byteEn = '1;
`endif
    logic          respValid;
    logic [DW-1:0] readData;
    logic          addrErr;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .memWrite  (memWrite),
        .address   (address),
        .writeData (writeData),
`ifdef DMEM_BYTE_EN
        .byteEn    (byteEn),
`endif
        .respValid (respValid),
        .readData  (readData),
        .addrErr   (addrErr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------- model
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clear_left = 0;
    logic          m_rv  = 1'b0;
    logic          m_err = 1'b0;
    logic [DW-1:0] m_rd  = '0;
    logic          started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            started      = 1'b1;
            m_clear_left = DEPTH;
            m_rv         = 1'b0;
            m_err        = 1'b0;
            m_rd         = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (started) begin
            logic acc;
            acc = reqValid && (m_clear_left == 0);
            if (m_clear_left > 0) m_clear_left = m_clear_left - 1;
            m_rv  = acc;
            m_err = acc && (int'(address) >= DEPTH);
            if (acc && !memWrite) begin
                m_rd = (int'(address) < DEPTH) ? m_mem[address] : '0;
            end
            if (acc && memWrite && int'(address) < DEPTH) begin
`ifdef DMEM_BYTE_EN
                for (int b = 0; b < DW/8; b++)
                    if (byteEn[b]) m_mem[address][b*8 +: 8] = writeData[b*8 +: 8];
`else
                m_mem[address] = writeData;
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: sample all outputs on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("busy",      32'(busy),      32'(m_clear_left > 0));
            chk("reqReady",  32'(reqReady),  32'(m_clear_left == 0));
            chk("respValid", 32'(respValid), 32'(m_rv));
            chk("addrErr",   32'(addrErr),   32'(m_err));
            chk("readData",  32'(readData),  32'(m_rd));
        end
    end

    // ----------------------------------------------------------- stimulus
    task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        @(negedge clk);
        reqValid  = v;
        memWrite  = w;
        address   = a;
        writeData = d;
    endtask

    // Hold reset for one edge, keep an FFFF write request asserted through
    // the clear, and return once the block is ready.
    task automatic reset_and_clear(input logic check_len);
        int cnt;
        @(negedge clk);
        reset = 1'b1; reqValid = 1'b1; memWrite = 1'b1;
        address = 16'h0003; writeData = 16'hFFFF;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        reqValid = 1'b0;
        if (cnt >= 1000) chk("clear_timeout", 32'(cnt), 32'd256);
        if (check_len) chk("busy_cycles", 32'(cnt), 32'd256);
    endtask

    initial begin
        // Reset with a write request held high through the clear.
        reset_and_clear(1'b1);
        chk("ready_after_clear", 32'(reqReady), 32'd1);
        foreach (address[i]) begin end
        step(1, 0, 16'h0003, 0);
        step(1, 0, 16'h00FF, 0);
        chk("rd0003_after_ffff_in_clear", 32'(readData), 32'h0000);
        step(0, 0, 0, 0);
        chk("rd00FF_zero", 32'(readData), 32'h0000);

        // Write then read the same address back-to-back.
        step(1, 1, 16'h000E, 16'h000E);
        step(1, 0, 16'h000E, 0);
        chk("wr_resp", 32'(respValid), 32'd1);
        step(0, 0, 0, 0);
        chk("rd_resp", 32'(respValid), 32'd1);
        chk("rd000E", 32'(readData), 32'h000E);
        chk("rd000E_err", 32'(addrErr), 32'd0);

        // Out-of-range read and write.
        step(1, 0, 16'h0100, 0);
        step(1, 1, 16'h0100, 16'hBEEF);
        chk("oor_rd_err", 32'(addrErr), 32'd1);
        chk("oor_rd_data", 32'(readData), 32'h0000);
        step(1, 0, 16'h0000, 0);
        chk("oor_wr_err", 32'(addrErr), 32'd1);
        step(0, 0, 0, 0);
        chk("word0_intact", 32'(readData), 32'h0000);
        chk("no_err_inrange", 32'(addrErr), 32'd0);

`ifdef DMEM_BYTE_EN
        step(1, 1, 16'h0005, 16'hABCD);
        step(1, 1, 16'h0005, 16'h1234); byteEn = 2'b01;
        step(1, 0, 16'h0005, 0); byteEn = 2'b11;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("byte_merge", 32'(readData), 32'h0000AB34);
`endif

        // Three writes, then reset mid-traffic.
        step(1, 1, 16'h0010, 16'h1111);
        step(1, 1, 16'h0011, 16'h2222);
        step(1, 1, 16'h0012, 16'h3333);
        reset_and_clear(1'b1);
        step(1, 0, 16'h0010, 0);
        step(1, 0, 16'h0012, 0);
        chk("rd0010_after_reset", 32'(readData), 32'h0000);
        step(0, 0, 0, 0);
        chk("rd0012_after_reset", 32'(readData), 32'h0000);

        // Randomized traffic with occasional resets; the model checks each cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 7) == 0) a = AW'($urandom);
            else                           a = AW'($urandom_range(0, 31));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, DW'($urandom));
`ifdef DMEM_BYTE_EN
            byteEn = (DW/8)'($urandom);
`endif
            if (n == 1500) begin
                reset_and_clear(1'b0);
            end
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
